// File: rtl/screen_mem_arbiter_pkg.sv
// Shared types for the screen memory arbiter: CPU op state and per-cycle grant tag.
package screen_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_PEND,
    C_RDWAIT
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_CPU_RD,
    GNT_CPU_WR
  } grant_t;

endpackage

// File: rtl/screen_mem_arbiter_if.sv
// CPU, VGA and screen-RAM signal bundle; the arbiter takes the slave view.
interface screen_mem_arbiter_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 4
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_rvalid;
  logic          vga_miss;
  logic [DW-1:0] vga_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, vga_rvalid, vga_miss, vga_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, vga_rvalid, vga_miss, vga_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/screen_mem_arbiter.sv
// Arbitrates the single-port screen RAM between VGA fetches (priority) and one
// in-flight CPU op, with a starvation counter that forces a CPU slot.
module screen_mem_arbiter
  import screen_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 11,
  parameter int unsigned DW         = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic                clk,
  input logic                reset,
  screen_mem_arbiter_if.slave bus
);

  localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state_q, state_d;
  grant_t        grant, tag_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          p_we_q;
  logic [AW-1:0] p_addr_q;
  logic [DW-1:0] p_wdata_q;
  logic [DW-1:0] held_q;
  logic          vga_denied, vga_denied_q;
  logic          accept;
  logic          starved;

  assign accept  = (state_q == C_IDLE) && bus.cpu_req;
  assign starved = (state_q == C_PEND) && (starve_q == STARVE_LIM);

  // Grant is forced to none while reset is asserted so the RAM sees no strobe.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      grant = GNT_NONE;
    end else if (bus.vga_req && !starved) begin
      grant = GNT_VGA;
    end else if (state_q == C_PEND) begin
      grant = p_we_q ? GNT_CPU_WR : GNT_CPU_RD;
    end
  end

  assign vga_denied = bus.vga_req && (grant != GNT_VGA);

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (grant)
      GNT_VGA: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.vga_addr;
      end
      GNT_CPU_RD, GNT_CPU_WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = (grant == GNT_CPU_WR);
        bus.mem_addr  = p_addr_q;
        bus.mem_wdata = p_wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE:   if (accept) state_d = C_PEND;
      C_PEND: begin
        if (grant == GNT_CPU_WR)      state_d = C_IDLE;
        else if (grant == GNT_CPU_RD) state_d = C_RDWAIT;
      end
      C_RDWAIT: state_d = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if ((state_q == C_PEND) && (grant == GNT_VGA)) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= C_IDLE;
      starve_q     <= '0;
      tag_q        <= GNT_NONE;
      vga_denied_q <= 1'b0;
      held_q       <= '0;
      p_we_q       <= 1'b0;
      p_addr_q     <= '0;
      p_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      tag_q        <= grant;
      vga_denied_q <= vga_denied;
      if (tag_q == GNT_VGA) held_q <= bus.mem_rdata;
      if (accept) begin
        p_we_q    <= bus.cpu_we;
        p_addr_q  <= bus.cpu_addr;
        p_wdata_q <= bus.cpu_wdata;
      end
    end
  end

  assign bus.cpu_ready  = (state_q == C_IDLE);
  assign bus.cpu_rvalid = (tag_q == GNT_CPU_RD);
  assign bus.cpu_rdata  = (tag_q == GNT_CPU_RD) ? bus.mem_rdata : '0;
  assign bus.vga_rvalid = (tag_q == GNT_VGA) || vga_denied_q;
  assign bus.vga_miss   = vga_denied_q;

  always_comb begin
    bus.vga_rdata = '0;
    if (tag_q == GNT_VGA)  bus.vga_rdata = bus.mem_rdata;
    else if (vga_denied_q) bus.vga_rdata = held_q;
  end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed plus randomized bench for screen_mem_arbiter against a transaction-level
// model of the arbitration rules and an expected-contents copy of the screen RAM.
module tb_screen_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 4;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  screen_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  screen_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read single-port RAM.
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] rd_q = '0;
  assign bus.mem_rdata = rd_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            rd_q <= ram[bus.mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_miss  = 0;

  // Reference model state
  int m_mem [2**AW];
  bit m_pend, m_rdwait, m_cret, op_we;
  int op_addr, op_wdata, m_waits, m_cval, m_vret, m_vval, m_held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_rdwait = 0; m_cret = 0; op_we = 0;
    op_addr = 0; op_wdata = 0; m_waits = 0; m_cval = 0;
    m_vret = 0; m_vval = 0; m_held = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"},     bus.mem_en, 0);
    chk({tag, "_cpu_ready"},  bus.cpu_ready, 1);
    chk({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
    chk({tag, "_vga_rvalid"}, bus.vga_rvalid, 0);
    chk({tag, "_vga_miss"},   bus.vga_miss, 0);
    chk({tag, "_cpu_rdata"},  bus.cpu_rdata, 0);
    chk({tag, "_vga_rdata"},  bus.vga_rdata, 0);
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance model.
  task automatic step(input bit creq, input bit cwe, input int caddr, input int cwd,
                      input bit vreq, input int vaddr);
    bit ready, cpu_win;
    int e_en, e_we, e_addr, e_wd, e_vd;
    @(negedge clk);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = AW'(caddr);
    bus.cpu_wdata = DW'(cwd);
    bus.vga_req   = vreq;
    bus.vga_addr  = AW'(vaddr);
    #1;
    ready   = !m_pend && !m_rdwait;
    cpu_win = m_pend && (!vreq || m_waits >= SM);
    e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
    if (vreq && !cpu_win) begin
      e_en = 1; e_addr = vaddr;
    end else if (cpu_win) begin
      e_en = 1; e_we = op_we; e_addr = op_addr; e_wd = op_wdata;
    end
    e_vd = (m_vret == 1) ? m_vval : (m_vret == 2) ? m_held : 0;
    chk("cpu_ready",  bus.cpu_ready, ready);
    chk("cpu_rvalid", bus.cpu_rvalid, m_cret);
    chk("cpu_rdata",  bus.cpu_rdata, m_cret ? m_cval : 0);
    chk("vga_rvalid", bus.vga_rvalid, m_vret != 0);
    chk("vga_miss",   bus.vga_miss, m_vret == 2);
    chk("vga_rdata",  bus.vga_rdata, e_vd);
    chk("mem_en",     bus.mem_en, e_en);
    chk("mem_we",     bus.mem_we, e_we);
    chk("mem_addr",   bus.mem_addr, e_addr);
    chk("mem_wdata",  bus.mem_wdata, e_wd);
    if (bus.vga_miss) n_miss++;
    if (m_vret == 1) m_held = m_vval;
    m_vret   = vreq ? (cpu_win ? 2 : 1) : 0;
    m_vval   = m_mem[vaddr];
    m_cret   = 0;
    m_rdwait = 0;
    if (cpu_win) begin
      if (op_we) m_mem[op_addr] = op_wdata;
      else begin
        m_cret = 1; m_cval = m_mem[op_addr]; m_rdwait = 1;
      end
      m_pend = 0; m_waits = 0;
    end else if (vreq && m_pend) begin
      m_waits++;
    end
    if (ready && creq) begin
      m_pend = 1; op_we = cwe; op_addr = caddr; op_wdata = cwd; m_waits = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int miss0;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = '0; m_mem[i] = 0;
    end
    model_reset();
    reset = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vga_req = 0; bus.vga_addr = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;

    // Plain write with idle VGA
    step(1, 1, 'h100, 'h5, 0, 0);
    idle(3);

    // Read-back of a freshly written location
    step(1, 1, 'h010, 'h9, 0, 0);
    idle(2);
    step(1, 0, 'h010, 0, 0, 0);
    idle(3);

    // Continuous VGA: write must be forced through after STARVE_MAX cycles
    miss0 = n_miss;
    step(1, 1, 'h020, 'hA, 1, $urandom_range(0, 2**AW - 1));
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, $urandom_range(0, 2**AW - 1));
    idle(2);
    chk("starve_miss_once", n_miss - miss0, 1);

    // VGA gaps every 4th cycle: pending read fits in a gap, no miss
    miss0 = n_miss;
    step(1, 0, 'h100, 0, 1, 'h020);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, (i % 4) != 3, 'h010);
    idle(2);
    chk("gap_no_miss", n_miss - miss0, 0);

    // Top address write then read
    step(1, 1, 'h7FF, 'h3, 0, 0);
    idle(2);
    step(1, 0, 'h7FF, 0, 0, 0);
    idle(3);

    // Reset while a write is held pending by VGA traffic
    step(1, 1, 'h055, 'h7, 1, 'h001);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 'h002);
    @(negedge clk);
    bus.cpu_req = 0;
    #1 reset = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk);
    chk_reset_outputs("hold_reset");
    bus.vga_req = 0;
    reset = 1'b1;
    model_reset();
    step(1, 0, 'h055, 0, 0, 0);
    idle(3);

    // Randomized traffic over a small address pool to exercise read-after-write
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) * 'h101,
           $urandom_range(0, 15), $urandom_range(0, 9) < 8,
           $urandom_range(0, 7) * 'h101);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
